sdl_video_out: RTL and testbench
================================

Name: sdl_video_out

Overview:
- Parametrised simulation video output stage between the display timing generator, the pixel sources and the SDL harness.
- Replaces the fixed single-source, 4-bit to 8-bit output register.
- Delays sync and coordinates to match pixel-source latency, composites LAYERS sources by priority over a background colour, and expands CHANW-bit channels to 8 bits.
- Counts output frames.

Parameters:
- CORDW, 12: signed coordinate width.
- CHANW, 4: input colour channel width, 1..8.
- LAYERS, 2: number of pixel sources, 1..4; layer 0 has highest priority.
- LAT, 2: pixel-source latency in clk_pix cycles relative to sx/sy/de/frame, 0..8.
- FCW, 16: frame counter width.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  reset, synchronous, active-high.
- sx  in  CORDW  signed horizontal position from timing generator.
- sy  in  CORDW  signed vertical position.
- de  in  1  data enable (low in blanking).
- frame  in  1  one-cycle start-of-frame pulse.
- layer_rgb  in  LAYERS*3*CHANW  per layer {r,g,b}; layer i occupies bits [i*3*CHANW +: 3*CHANW].
- layer_opaque  in  LAYERS  per-layer pixel-valid/opaque flag, same timing as layer_rgb.
- bg_rgb  in  3*CHANW  background colour {r,g,b}, sampled every cycle.
- sdl_sx  out  CORDW  aligned horizontal position.
- sdl_sy  out  CORDW  aligned vertical position.
- sdl_de  out  1  aligned data enable.
- sdl_frame  out  1  aligned frame pulse.
- sdl_r  out  8  red.
- sdl_g  out  8  green.
- sdl_b  out  8  blue.
- frame_count  out  FCW  number of sdl_frame pulses since reset.

Behaviour:
- Alignment: sx, sy, de and frame pass through a LAT-stage shift register.
  - Stage LAT output is time-aligned with layer_rgb/layer_opaque.
  - LAT=0 means no delay stages.
- Output register: one stage after alignment. Total latency from sx/sy/de/frame to sdl_* is LAT+1 cycles. Layer/bg data to sdl_r/g/b is 1 cycle.
- Compositing: select the lowest index i with layer_opaque[i]=1. If none is set, select bg_rgb.
- Blanking: aligned de=0 forces sdl_r/g/b=0 regardless of layers.
- Expansion: each 8-bit channel is the CHANW-bit value replicated MSB-first and truncated to 8 bits.
  - CHANW=4: {c,c}.
  - CHANW=3: {c,c,c[2:1]}.
  - CHANW=8: c.
  - CHANW=1: {8{c}}.
  - Full scale maps to 0xFF; zero maps to 0x00.
- frame_count: increments by 1 in the cycle after sdl_frame is registered high, i.e. on the cycle frame leaves stage LAT. Wraps 2^FCW-1 -> 0 with no flag.
- Reset (rst_pix high at a clk_pix edge):
  - All delay stages clear to 0, so de and frame are 0 in the pipe.
  - All sdl_* outputs become 0; frame_count becomes 0.
  - Reset mid-frame: outputs stay 0 for LAT+1 cycles after reset release, while the pipe refills.
  - A frame pulse in the pipe at reset is discarded and not counted.
- No internal state machine beyond the pipeline and counter. Behaviour is identical every cycle; no back-pressure.

Optional Feature:
- Macro: SDL_VIDEO_OUT_GRID_EN.
- When defined: adds parameter GRID_SHIFT (default 5) and input grid_on (1 bit, registered with the aligned stage).
  - When grid_on=1 and aligned de=1, a pixel whose aligned sx or sy has its low GRID_SHIFT bits all zero outputs 0xFF on all three channels.
  - The grid overrides all layers and the background. Latency is unchanged.
- When undefined: no grid_on port and no grid logic; output is pure composite.

Test Plan:
- Reset then free-run, LAT=2, CHANW=4: drive sx ramp 0,1,2... -> sdl_sx equals sx from 3 cycles earlier. sdl_r/g/b and frame_count are 0 during reset.
- Layer priority, LAYERS=2:
  - layer0={F,0,0} opaque and layer1={0,F,0} opaque, de=1 -> sdl={FF,00,00}.
  - Clear opaque[0] -> {00,FF,00}.
  - Clear both with bg={0,0,8} -> {00,00,88}.
- Blanking: same opaque layers with de=0 in the aligned slot -> sdl_r/g/b=0, sdl_de=0.
- Expansion sweep, CHANW=3: c=7 -> 0xFF, c=5 -> 0xB6, c=1 -> 0x24, c=0 -> 0x00. LAT=0 build -> coordinate latency is 1 cycle.
- frame_count, FCW=4: 17 frame pulses -> count reads 1 after the 17th, wrapping through 0 at the 16th.
- Reset mid-frame, plus a SDL_VIDEO_OUT_GRID_EN build:
  - Assert rst_pix one cycle with a frame pulse in the pipe -> frame_count stays 0; outputs stay 0 for LAT+1 cycles.
  - With the grid build, GRID_SHIFT=5 and grid_on=1: sx=32 or sy=64 -> 0xFFFFFF; sx=33, sy=1 -> composite colour.

Source files
------------

// File: rtl/sdl_video_out.sv
// rtl/sdl_video_out.sv - latency-aligned layer compositor and 8-bit channel expander for the SDL harness; optional grid overlay under SDL_VIDEO_OUT_GRID_EN
module sdl_video_out #(
  parameter int CORDW  = 12,
  parameter int CHANW  = 4,
  parameter int LAYERS = 2,
  parameter int LAT    = 2,
  parameter int FCW    = 16
`ifdef SDL_VIDEO_OUT_GRID_EN
  ,
  parameter int GRID_SHIFT = 5
`endif
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix,
  input  logic signed [CORDW-1:0]    sx,
  input  logic signed [CORDW-1:0]    sy,
  input  logic                       de,
  input  logic                       frame,
  input  logic [LAYERS*3*CHANW-1:0]  layer_rgb,
  input  logic [LAYERS-1:0]          layer_opaque,
  input  logic [3*CHANW-1:0]         bg_rgb,
`ifdef SDL_VIDEO_OUT_GRID_EN
  input  logic                       grid_on,
`endif
  output logic signed [CORDW-1:0]    sdl_sx,
  output logic signed [CORDW-1:0]    sdl_sy,
  output logic                       sdl_de,
  output logic                       sdl_frame,
  output logic [7:0]                 sdl_r,
  output logic [7:0]                 sdl_g,
  output logic [7:0]                 sdl_b,
  output logic [FCW-1:0]             frame_count
);

  // Timing signals as seen in the same cycle as the pixel-source data.
  logic signed [CORDW-1:0] al_sx;
  logic signed [CORDW-1:0] al_sy;
  logic                    al_de;
  logic                    al_frame;

  generate
    if (LAT == 0) begin : g_nodly
      assign al_sx    = sx;
      assign al_sy    = sy;
      assign al_de    = de;
      assign al_frame = frame;
    end else begin : g_dly
      logic signed [CORDW-1:0] sx_q    [LAT];
      logic signed [CORDW-1:0] sy_q    [LAT];
      logic                    de_q    [LAT];
      logic                    frame_q [LAT];

      // Shift timing signals down the pipe; reset empties it so stale frames are dropped.
      always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
          for (int i = 0; i < LAT; i++) begin
            sx_q[i]    <= '0;
            sy_q[i]    <= '0;
            de_q[i]    <= 1'b0;
            frame_q[i] <= 1'b0;
          end
        end else begin
          sx_q[0]    <= sx;
          sy_q[0]    <= sy;
          de_q[0]    <= de;
          frame_q[0] <= frame;
          for (int i = 1; i < LAT; i++) begin
            sx_q[i]    <= sx_q[i-1];
            sy_q[i]    <= sy_q[i-1];
            de_q[i]    <= de_q[i-1];
            frame_q[i] <= frame_q[i-1];
          end
        end
      end

      assign al_sx    = sx_q[LAT-1];
      assign al_sy    = sy_q[LAT-1];
      assign al_de    = de_q[LAT-1];
      assign al_frame = frame_q[LAT-1];
    end
  endgenerate

  // Replicate the channel MSB-first to fill 8 bits so full scale lands on 0xFF.
  function automatic logic [7:0] expand(input logic [CHANW-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      e[7-k] = c[CHANW-1-(k % CHANW)];
    end
    return e;
  endfunction

  logic [3*CHANW-1:0] pix;
  logic [23:0]        rgb_d;
  logic [23:0]        rgb_q;
  logic signed [CORDW-1:0] sx_out_q;
  logic signed [CORDW-1:0] sy_out_q;
  logic               de_out_q;
  logic               frame_out_q;
  logic [FCW-1:0]     fc_d;
  logic [FCW-1:0]     fc_q;

  // Pick the highest-priority opaque layer (lowest index), expand, then apply overlay and blanking.
  always_comb begin
    pix = bg_rgb;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (layer_opaque[i]) begin
        pix = layer_rgb[i*3*CHANW +: 3*CHANW];
      end
    end
    rgb_d = {expand(pix[3*CHANW-1 -: CHANW]),
             expand(pix[2*CHANW-1 -: CHANW]),
             expand(pix[CHANW-1:0])};
`ifdef SDL_VIDEO_OUT_GRID_EN
    if (grid_on && ((al_sx[GRID_SHIFT-1:0] == '0) || (al_sy[GRID_SHIFT-1:0] == '0))) begin
      rgb_d = '1;
    end
`endif
    if (!al_de) begin
      rgb_d = '0;
    end
    fc_d = fc_q + FCW'(frame_out_q);
  end

  // Output register; the counter advances one cycle after a frame pulse is presented.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx_out_q    <= '0;
      sy_out_q    <= '0;
      de_out_q    <= 1'b0;
      frame_out_q <= 1'b0;
      rgb_q       <= '0;
      fc_q        <= '0;
    end else begin
      sx_out_q    <= al_sx;
      sy_out_q    <= al_sy;
      de_out_q    <= al_de;
      frame_out_q <= al_frame;
      rgb_q       <= rgb_d;
      fc_q        <= fc_d;
    end
  end

  assign sdl_sx      = sx_out_q;
  assign sdl_sy      = sy_out_q;
  assign sdl_de      = de_out_q;
  assign sdl_frame   = frame_out_q;
  assign sdl_r       = rgb_q[23:16];
  assign sdl_g       = rgb_q[15:8];
  assign sdl_b       = rgb_q[7:0];
  assign frame_count = fc_q;

endmodule

// File: tb/tb_sdl_video_out.sv
// tb/tb_sdl_video_out.sv - table-driven scoreboard bench for sdl_video_out
module tb_sdl_video_out;

  localparam int LAT = 2;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic               rst_r;
  logic signed [11:0] sx_r, sy_r;
  logic               de_r, frame_r;
  logic [23:0]        lrgb_r;
  logic [1:0]         op_r;
  logic [11:0]        bg_r;
  logic signed [11:0] o_sx, o_sy;
  logic               o_de, o_frame;
  logic [7:0]         o_r, o_g, o_b;
  logic [3:0]         o_fc;
`ifdef SDL_VIDEO_OUT_GRID_EN
  logic               grid_r;
  logic               e_grid;
`endif

  sdl_video_out #(.CORDW(12), .CHANW(4), .LAYERS(2), .LAT(LAT), .FCW(4)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_r), .sx(sx_r), .sy(sy_r), .de(de_r), .frame(frame_r),
    .layer_rgb(lrgb_r), .layer_opaque(op_r), .bg_rgb(bg_r),
`ifdef SDL_VIDEO_OUT_GRID_EN
    .grid_on(grid_r),
`endif
    .sdl_sx(o_sx), .sdl_sy(o_sy), .sdl_de(o_de), .sdl_frame(o_frame),
    .sdl_r(o_r), .sdl_g(o_g), .sdl_b(o_b), .frame_count(o_fc)
  );

  logic signed [11:0] e_sx, e_sy;
  logic               e_de, e_frame;
  logic [8:0]         e_rgb, e_bg;
  logic [0:0]         e_op;
  logic signed [11:0] e_osx, e_osy;
  logic               e_ode, e_ofr;
  logic [7:0]         e_r, e_g, e_b, e_fc;

  sdl_video_out #(.CORDW(12), .CHANW(3), .LAYERS(1), .LAT(0), .FCW(8)) dut_e (
    .clk_pix(clk_pix), .rst_pix(rst_r), .sx(e_sx), .sy(e_sy), .de(e_de), .frame(e_frame),
    .layer_rgb(e_rgb), .layer_opaque(e_op), .bg_rgb(e_bg),
`ifdef SDL_VIDEO_OUT_GRID_EN
    .grid_on(e_grid),
`endif
    .sdl_sx(e_osx), .sdl_sy(e_osy), .sdl_de(e_ode), .sdl_frame(e_ofr),
    .sdl_r(e_r), .sdl_g(e_g), .sdl_b(e_b), .frame_count(e_fc)
  );

  typedef struct {
    logic signed [11:0] sx, sy;
    logic               de, frame, grid;
    logic [1:0]         op;
    logic [11:0]        l0, l1, bg;
    logic [23:0]        exp_rgb;
  } vec_t;

  typedef struct {
    int                 due;
    logic signed [11:0] sx, sy;
    logic               de, frame;
    logic [23:0]        rgb;
    logic [3:0]         fc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [3:0] fc_model;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic add(input logic signed [11:0] sx, input logic signed [11:0] sy, input logic de,
                     input logic frame, input logic grid, input logic [1:0] op,
                     input logic [11:0] l0, input logic [11:0] l1, input logic [11:0] bg,
                     input logic [23:0] exp_rgb);
    vec_t v;
    v.sx = sx; v.sy = sy; v.de = de; v.frame = frame; v.grid = grid;
    v.op = op; v.l0 = l0; v.l1 = l1; v.bg = bg; v.exp_rgb = exp_rgb;
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk_pix);
    cyc++;
    #1;
  endtask

  typedef struct { logic [8:0] rgb; logic op; logic [8:0] bg; logic [23:0] exp_rgb; } evec_t;
  evec_t evecs[$];

  initial begin
    rst_r = 1'b1; sx_r = 12'sd5; sy_r = 12'sd6; de_r = 1'b1; frame_r = 1'b1;
    lrgb_r = 24'hFFF_FFF; op_r = 2'b11; bg_r = 12'hFFF;
    e_sx = '0; e_sy = '0; e_de = 1'b0; e_frame = 1'b0; e_rgb = '0; e_op = 1'b0; e_bg = '0;
`ifdef SDL_VIDEO_OUT_GRID_EN
    grid_r = 1'b0; e_grid = 1'b0;
`endif
    fc_model = '0;

    // vector table: coordinates are driven LAT cycles ahead of the matching layer data
    for (int i = 0; i < 8; i++) add(12'(i), 12'sd5, 1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 12'h000, 12'h123, 24'h112233);
    add(12'sd10, 12'sd7, 1'b1, 1'b0, 1'b0, 2'b11, 12'hF00, 12'h0F0, 12'h000, 24'hFF0000);
    add(12'sd11, 12'sd7, 1'b1, 1'b0, 1'b0, 2'b10, 12'hF00, 12'h0F0, 12'h000, 24'h00FF00);
    add(12'sd12, 12'sd7, 1'b1, 1'b0, 1'b0, 2'b00, 12'hF00, 12'h0F0, 12'h008, 24'h000088);
    add(12'sd13, 12'sd7, 1'b0, 1'b0, 1'b0, 2'b11, 12'hF00, 12'h0F0, 12'h008, 24'h000000);
    add(12'sd14, -12'sd3, 1'b1, 1'b0, 1'b0, 2'b01, 12'hA53, 12'h0F0, 12'h008, 24'hAA5533);
    add(12'sd15, 12'sd7, 1'b1, 1'b0, 1'b0, 2'b11, 12'hFFF, 12'h000, 12'h000, 24'hFFFFFF);
    for (int i = 0; i < 17; i++) begin
      add(12'(100 + i), 12'sd9, 1'b0, 1'b1, 1'b0, 2'b11, 12'hF00, 12'h0F0, 12'h000, 24'h000000);
      add(12'(200 + i), 12'sd9, 1'b1, 1'b0, 1'b0, 2'b00, 12'hF00, 12'h0F0, 12'h123, 24'h112233);
    end
`ifdef SDL_VIDEO_OUT_GRID_EN
    add(12'sd32, 12'sd3,  1'b1, 1'b0, 1'b1, 2'b01, 12'h123, 12'h000, 12'h000, 24'hFFFFFF);
    add(12'sd5,  12'sd64, 1'b1, 1'b0, 1'b1, 2'b01, 12'h123, 12'h000, 12'h000, 24'hFFFFFF);
    add(12'sd33, 12'sd1,  1'b1, 1'b0, 1'b1, 2'b01, 12'h123, 12'h000, 12'h000, 24'h112233);
    add(12'sd0,  12'sd0,  1'b0, 1'b0, 1'b1, 2'b01, 12'h123, 12'h000, 12'h000, 24'h000000);
    add(12'sd0,  12'sd0,  1'b1, 1'b0, 1'b0, 2'b01, 12'h123, 12'h000, 12'h000, 24'h112233);
`endif

    evecs.push_back('{9'o777, 1'b1, 9'o000, 24'hFFFFFF});
    evecs.push_back('{9'o555, 1'b1, 9'o000, 24'hB6B6B6});
    evecs.push_back('{9'o111, 1'b1, 9'o000, 24'h242424});
    evecs.push_back('{9'o000, 1'b1, 9'o777, 24'h000000});
    evecs.push_back('{9'o777, 1'b0, 9'o517, 24'hB624FF});

    // reset with junk on every input: outputs and counter must hold zero
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rgb", {o_r, o_g, o_b}, 24'h0);
      chk("rst_de", o_de, 1'b0);
      chk("rst_fc", o_fc, 4'h0);
    end
    rst_r = 1'b0;

    // skewed application of the table with scoreboard checking
    for (int k = 0; k < vecs.size() + LAT; k++) begin
      if (k < vecs.size()) begin
        sx_r = vecs[k].sx; sy_r = vecs[k].sy; de_r = vecs[k].de; frame_r = vecs[k].frame;
      end else begin
        de_r = 1'b0; frame_r = 1'b0;
      end
      if (k >= LAT) begin
        exp_t e;
        int j;
        j = k - LAT;
        lrgb_r = {vecs[j].l1, vecs[j].l0}; op_r = vecs[j].op; bg_r = vecs[j].bg;
`ifdef SDL_VIDEO_OUT_GRID_EN
        grid_r = vecs[j].grid;
`endif
        e.due = cyc + 1; e.sx = vecs[j].sx; e.sy = vecs[j].sy; e.de = vecs[j].de;
        e.frame = vecs[j].frame; e.rgb = vecs[j].exp_rgb; e.fc = fc_model;
        sb.push_back(e);
        fc_model = fc_model + 4'(vecs[j].frame);
      end else begin
        op_r = 2'b00; bg_r = 12'h000;
      end
      tick();
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("sdl_sx", o_sx, e.sx);
        chk("sdl_sy", o_sy, e.sy);
        chk("sdl_de", o_de, e.de);
        chk("sdl_frame", o_frame, e.frame);
        chk("sdl_rgb", {o_r, o_g, o_b}, e.rgb);
        chk("frame_count", o_fc, e.fc);
      end
    end
    chk("sb_drained", sb.size(), 0);
    tick();
    chk("fc_after_17", o_fc, 4'd1);

    // reset with a frame pulse in flight: it must be discarded, outputs refill after LAT+1
    sx_r = 12'sd7; de_r = 1'b1; frame_r = 1'b1; op_r = 2'b01; lrgb_r = 24'h000_FFF;
    tick();
    rst_r = 1'b1; frame_r = 1'b0; sx_r = 12'sd8;
    tick();
    chk("midrst_rgb", {o_r, o_g, o_b}, 24'h0);
    chk("midrst_fc", o_fc, 4'h0);
    rst_r = 1'b0;
    for (int j = 0; j < 6; j++) begin
      sx_r = 12'(20 + j);
      tick();
      chk("refill_fc", o_fc, 4'h0);
      chk("refill_frame", o_frame, 1'b0);
      if (j < LAT) begin
        chk("refill_rgb0", {o_r, o_g, o_b}, 24'h0);
        chk("refill_de0", o_de, 1'b0);
      end else begin
        chk("refill_rgb", {o_r, o_g, o_b}, 24'hFFFFFF);
        chk("refill_de", o_de, 1'b1);
        chk("refill_sx", o_sx, 12'(20 + j - LAT));
      end
    end

    // CHANW=3, LAT=0 instance: expansion sweep and single-cycle coordinate latency
    e_de = 1'b1; e_sy = 12'sd2;
    for (int i = 0; i < evecs.size(); i++) begin
      e_sx = 12'(40 + i); e_rgb = evecs[i].rgb; e_op = evecs[i].op; e_bg = evecs[i].bg;
      tick();
      chk("exp_rgb", {e_r, e_g, e_b}, evecs[i].exp_rgb);
      chk("exp_sx", e_osx, 12'(40 + i));
    end
    e_frame = 1'b1;
    tick();
    e_frame = 1'b0;
    chk("l0_frame", e_ofr, 1'b1);
    chk("l0_fc_pre", e_fc, 8'd0);
    tick();
    chk("l0_fc_post", e_fc, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
